// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizing helpers and FSM encoding for the FFT sequencer
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_e;

    function automatic int fft_log2n(input int n);
        return $clog2(n);
    endfunction

    function automatic int fft_stage_w(input int n);
        return $clog2($clog2(n));
    endfunction

    function automatic int fft_pair_w(input int n);
        return $clog2(n / 2);
    endfunction

    function automatic int fft_pipe_lat(input int bfly_latency);
        return 1 + bfly_latency;
    endfunction

endpackage

// File: rtl/fft_valid_delay.sv
// rtl/fft_valid_delay.sv - holdable valid shift register giving read (tap 1) and write (tap DEPTH) strobes
module fft_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic din,
    output logic rd_tap,
    output logic wr_tap
);

    logic [DEPTH-1:0] shreg_q;
    logic [DEPTH-1:0] shreg_d;

    generate
        if (DEPTH == 1) begin : g_one
            always_comb shreg_d = hold ? shreg_q : din;
        end else begin : g_multi
            always_comb shreg_d = hold ? shreg_q : {shreg_q[DEPTH-2:0], din};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign rd_tap = shreg_q[0];
    assign wr_tap = shreg_q[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - radix-2 FFT stage/pair sequencer with inter-stage pipeline drain
// Optional input stall enabled by defining FFT_SEQ_STALL_EN.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N            = 32,
    parameter int BFLY_LATENCY = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
`ifdef FFT_SEQ_STALL_EN
    input  logic                              stall,
`endif
    output logic [fft_stage_w(N)-1:0]         agu_stage,
    output logic [fft_pair_w(N)-1:0]          agu_pair_id,
    output logic                              issue_valid,
    output logic                              rd_en,
    output logic                              wr_en,
    output logic                              busy,
    output logic                              done
);

    localparam int LOG2N    = fft_log2n(N);
    localparam int STAGE_W  = fft_stage_w(N);
    localparam int PAIR_W   = fft_pair_w(N);
    localparam int PIPE_LAT = fft_pipe_lat(BFLY_LATENCY);
    localparam int CNT_W    = $clog2(PIPE_LAT + 1);

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
    localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(N / 2 - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LEN  = CNT_W'(PIPE_LAT);

    logic hold;
`ifdef FFT_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    fft_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [PAIR_W-1:0]  pair_q, pair_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic               issue_q, issue_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        issue_d = issue_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    pair_d  = '0;
                    issue_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                pair_d = pair_q + PAIR_W'(1);
                if (pair_q == LAST_PAIR) begin
                    state_d = DRAIN;
                    issue_d = 1'b0;
                    drain_d = DRAIN_LEN;
                end
            end
            DRAIN: begin
                drain_d = drain_q - CNT_W'(1);
                if (drain_q == CNT_W'(1)) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + STAGE_W'(1);
                        pair_d  = '0;
                        issue_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stalled cycle is invisible to the sequence: everything, including a pending done, waits.
        if (hold) begin
            state_d = state_q;
            stage_d = stage_q;
            pair_d  = pair_q;
            drain_d = drain_q;
            issue_d = issue_q;
            busy_d  = busy_q;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            pair_q  <= '0;
            drain_q <= '0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    logic rd_tap, wr_tap;

    fft_valid_delay #(
        .DEPTH(PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .din   (issue_q),
        .rd_tap(rd_tap),
        .wr_tap(wr_tap)
    );

    assign agu_stage   = stage_q;
    assign agu_pair_id = pair_q;
    assign issue_valid = issue_q & ~hold;
    assign rd_en       = rd_tap & ~hold;
    assign wr_en       = wr_tap & ~hold;
    assign busy        = busy_q;
    assign done        = done_q & ~hold;

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - randomized check of fft_sequencer against a schedule-index model
module tb_fft_sequencer;

    localparam int N     = 8;
    localparam int BL    = 2;
    localparam int P     = BL + 1;
    localparam int LOG2N = 3;
    localparam int HALF  = N / 2;
    localparam int SLOT  = HALF + P;
    localparam int D     = 1 + LOG2N * SLOT;

    logic       clk = 1'b0;
    logic       reset, start, stall;
    logic [1:0] agu_stage;
    logic [1:0] agu_pair_id;
    logic       issue_valid, rd_en, wr_en, busy, done;

    logic       reset32, start32;
    logic [2:0] stage32;
    logic [3:0] pair32;
    logic       iv32, rd32, wr32, busy32, done32;
    logic       stall32 = 1'b0;

    always #5 clk = ~clk;

    fft_sequencer #(.N(N), .BFLY_LATENCY(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef FFT_SEQ_STALL_EN
        .stall      (stall),
`endif
        .agu_stage  (agu_stage),
        .agu_pair_id(agu_pair_id),
        .issue_valid(issue_valid),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done)
    );

    fft_sequencer dut32 (
        .clk        (clk),
        .reset      (reset32),
        .start      (start32),
`ifdef FFT_SEQ_STALL_EN
        .stall      (stall32),
`endif
        .agu_stage  (stage32),
        .agu_pair_id(pair32),
        .issue_valid(iv32),
        .rd_en      (rd32),
        .wr_en      (wr32),
        .busy       (busy32),
        .done       (done32)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Model: u counts non-stalled edges since start was accepted; the whole schedule follows from u.
    bit run = 1'b0;
    int u   = 0;
    int cyc_n = 0;

    function automatic bit iss(input int v);
        return (v >= 1) && (v <= D - 1) && (((v - 1) % SLOT) < HALF);
    endfunction

    bit log_en = 1'b0;
    int iss_t[$], rd_t[$], wr_t[$], done_t[$], stg_log[$], pair_log[$];
    int busy_n;

    task automatic clear_logs();
        iss_t.delete(); rd_t.delete(); wr_t.delete(); done_t.delete();
        stg_log.delete(); pair_log.delete(); busy_n = 0;
    endtask

    task automatic cyc(input logic s, input logic st, input logic r);
        bit e_iss, e_rd, e_wr, e_busy, e_done;
        @(negedge clk);
        start = s; stall = st; reset = r;
        #1;
        if (r) run = 1'b0;
        e_iss  = run && !st && iss(u);
        e_rd   = run && !st && iss(u - 1);
        e_wr   = run && !st && iss(u - P);
        e_busy = run && (u >= 1) && (u <= D - 1);
        e_done = run && !st && (u == D);
        chk("issue_valid", issue_valid, e_iss);
        chk("rd_en", rd_en, e_rd);
        chk("wr_en", wr_en, e_wr);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (e_iss) begin
            chk("agu_stage", agu_stage, (u - 1) / SLOT);
            chk("agu_pair_id", agu_pair_id, (u - 1) % SLOT);
        end
        if (log_en) begin
            if (issue_valid) begin
                iss_t.push_back(cyc_n); stg_log.push_back(agu_stage); pair_log.push_back(agu_pair_id);
            end
            if (rd_en) rd_t.push_back(cyc_n);
            if (wr_en) wr_t.push_back(cyc_n);
            if (done)  done_t.push_back(cyc_n);
            if (busy)  busy_n++;
        end
        @(posedge clk);
        if (r) begin
            run = 1'b0;
        end else if (!st) begin
            if (run) begin
                u++;
                if (u > D) run = 1'b0;
            end else if (s) begin
                run = 1'b1;
                u   = 1;
            end
        end
        cyc_n++;
    endtask

    task automatic full_run_check(input int exp_done, input bit stalled);
        int t0;
        logic st;
        clear_logs();
        log_en = 1'b1;
        t0 = cyc_n;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= exp_done + 3; k++) begin
            st = stalled && ((k >= 2 && k <= 6) || k == 11 || k == 12);
            cyc(1'b0, st, 1'b0);
        end
        log_en = 1'b0;
        chk("run_rd_count", rd_t.size(), 12);
        chk("run_wr_count", wr_t.size(), 12);
        chk("run_busy_cycles", busy_n, exp_done - 1);
        chk("run_done_count", done_t.size(), 1);
        if (done_t.size() >= 1) chk("run_done_cycle", done_t[0] - t0, exp_done);
        if (iss_t.size() == 12 && rd_t.size() == 12 && wr_t.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("seq_stage", stg_log[i], i / 4);
                chk("seq_pair", pair_log[i], i % 4);
                if (!stalled) begin
                    chk("issue_cycle", iss_t[i] - t0, 1 + (i / 4) * 7 + (i % 4));
                    chk("rd_gap", rd_t[i] - iss_t[i], 1);
                    chk("wr_gap", wr_t[i] - iss_t[i], 3);
                end
            end
            for (int k = 0; k < 2; k++)
                chk("raw_gap", rd_t[4 * (k + 1)] - wr_t[4 * k + 3], 2);
        end else begin
            chk("run_issue_count", iss_t.size(), 12);
        end
    endtask

    bit p32_done = 1'b0;

    initial begin
        int k, wr_n, rd_n, max_stage, done_k;
        reset32 = 1'b1; start32 = 1'b0;
        repeat (2) @(negedge clk);
        reset32 = 1'b0;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wr_n = 0; rd_n = 0; max_stage = 0; done_k = -1;
        for (k = 1; k <= 150 && done_k < 0; k++) begin
            #2;
            if (wr32) wr_n++;
            if (rd32) rd_n++;
            if (iv32 && stage32 > max_stage) max_stage = stage32;
            if (done32) done_k = k;
            @(negedge clk);
        end
        chk("n32_done_cycle", done_k, 101);
        chk("n32_wr_count", wr_n, 80);
        chk("n32_rd_count", rd_n, 80);
        chk("n32_max_stage", max_stage, 4);
        p32_done = 1'b1;
    end

    initial begin
        logic st;
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("reset_stage", agu_stage, 0);
        chk("reset_pair", agu_pair_id, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        full_run_check(22, 1'b0);

        clear_logs();
        log_en = 1'b1;
        repeat (80) cyc(1'b1, 1'b0, 1'b0);
        log_en = 1'b0;
        chk("b2b_done_count", done_t.size(), 3);
        if (done_t.size() >= 2) chk("b2b_period", done_t[1] - done_t[0], 23);
        repeat (30) cyc(1'b0, 1'b0, 1'b0);

        cyc(1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_async_issue", issue_valid, 0);
        chk("rst_async_wr", wr_en, 0);
        chk("rst_async_busy", busy, 0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        full_run_check(22, 1'b0);

`ifdef FFT_SEQ_STALL_EN
        full_run_check(29, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
`ifdef FFT_SEQ_STALL_EN
            st = ($urandom % 4) == 0;
`else
            st = 1'b0;
`endif
            cyc(($urandom % 6) == 0, st, ($urandom % 150) == 0);
        end

        for (int i = 0; i < 200 && !p32_done; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("n32_finished", p32_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
